// File: rtl/latch_bank_acc.sv
// Multi-channel latch bank: per-channel load/accumulate/clear on falling save strobes,
// plus a valid/ready sequencer that scans every channel value out in index order.
module latch_bank_acc #(
    parameter int NCH = 2,
    parameter int DW  = 4,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    save_n,
    input  logic [DW-1:0]     data_in,
    input  logic [1:0]        mode,
    output logic [NCH*DW-1:0] q,
    output logic [NCH-1:0]    ovf,
    input  logic              dump_start,
    output logic [DW-1:0]     out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [DW:0] add_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [DW-1:0] sat_sum(input logic [DW:0] s);
        return s[DW] ? {DW{1'b1}} : s[DW-1:0];
    endfunction

    logic [DW-1:0]  q_r [NCH];
    logic [DW:0]    sum_w [NCH];
    logic [NCH-1:0] save_hist;
    logic [NCH-1:0] fire;

    state_t         state, state_nxt;
    logic [CW-1:0]  ch_nxt;
    logic [DW-1:0]  data_nxt;

    // A channel fires only on the 1->0 transition of its strobe
    assign fire = save_hist & ~save_n;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sum_w[i] = add_ext(q_r[i], data_in);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign q[g*DW +: DW] = q_r[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                q_r[i] <= '0;
            end
            ovf       <= '0;
            save_hist <= '1;
        end else begin
            save_hist <= save_n;
            for (int i = 0; i < NCH; i++) begin
                if (fire[i]) begin
                    case (mode)
                        2'b00: begin
                            q_r[i] <= data_in;
                            ovf[i] <= 1'b0;
                        end
                        2'b01: begin
                            q_r[i] <= sum_w[i][DW-1:0];
                            if (sum_w[i][DW]) ovf[i] <= 1'b1;
                        end
                        2'b10: begin
                            q_r[i] <= sat_sum(sum_w[i]);
                            if (sum_w[i][DW]) ovf[i] <= 1'b1;
                        end
                        default: begin
                            q_r[i] <= '0;
                            ovf[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Readout sequencer: words are snapshots of q taken when they are loaded,
    // so later saves never disturb a word already on the stream
    always_comb begin
        state_nxt = state;
        ch_nxt    = out_ch;
        data_nxt  = out_data;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nxt = SEND;
                    ch_nxt    = '0;
                    data_nxt  = q_r[0];
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (out_ch == CW'(NCH - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        ch_nxt   = out_ch + CW'(1);
                        data_nxt = q_r[ch_nxt];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            out_ch   <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            out_ch   <= ch_nxt;
            out_data <= data_nxt;
        end
    end

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);

endmodule

// File: tb/tb_latch_bank_acc.sv
// Directed bench for latch_bank_acc (NCH=2, DW=4): direct checks of q/ovf/status,
// and a scoreboard queue drained by a monitor for every accepted readout word.
module tb_latch_bank_acc;

    localparam int NCH = 2;
    localparam int DW  = 4;
    localparam int CW  = 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    save_n;
    logic [DW-1:0]     data_in;
    logic [1:0]        mode;
    logic [NCH*DW-1:0] q;
    logic [NCH-1:0]    ovf;
    logic              dump_start;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;
    logic [CW+DW-1:0] exp_q[$];

    latch_bank_acc #(.NCH(NCH), .DW(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .save_n     (save_n),
        .data_in    (data_in),
        .mode       (mode),
        .q          (q),
        .ovf        (ovf),
        .dump_start (dump_start),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One save event: strobe low for a single cycle, then released
    task automatic save(input logic [NCH-1:0] sn, input logic [1:0] m, input logic [DW-1:0] d);
        save_n  = sn;
        mode    = m;
        data_in = d;
        tick();
        save_n = '1;
        tick();
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_extra: got ch=%0d data=0x%0h expected no word", out_ch, out_data);
            end else begin
                logic [CW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({out_ch, out_data} !== e) begin
                    errors++;
                    $display("FAIL word: got ch=%0d data=0x%0h expected ch=%0d data=0x%0h",
                             out_ch, out_data, e[CW+DW-1 -: CW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        save_n     = '1;
        data_in    = '0;
        mode       = 2'b00;
        dump_start = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk("rst_q", q, 8'h00);
        chk("rst_ovf", ovf, 2'b00);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        save(2'b10, 2'b00, 4'h9);
        chk("load_ch0", q, 8'h09);

        save_n  = 2'b10;
        mode    = 2'b01;
        data_in = 4'h1;
        repeat (5) tick();
        save_n = '1;
        tick();
        chk("hold_one_event", q, 8'h0A);
        chk("hold_ovf", ovf, 2'b00);

        save(2'b01, 2'b00, 4'hC);
        chk("load_ch1", q, 8'hCA);
        save(2'b01, 2'b01, 4'h7);
        chk("wrap_q", q, 8'h3A);
        chk("wrap_ovf", ovf, 2'b10);
        save(2'b01, 2'b01, 4'h1);
        chk("wrap_add1_q", q, 8'h4A);
        chk("wrap_sticky_ovf", ovf, 2'b10);
        save(2'b01, 2'b00, 4'hE);
        chk("load_clears_ovf", ovf, 2'b00);

        save(2'b10, 2'b00, 4'hE);
        chk("both_e", q, 8'hEE);
        save(2'b00, 2'b10, 4'h5);
        chk("sat_q", q, 8'hFF);
        chk("sat_ovf", ovf, 2'b11);
        save(2'b10, 2'b11, 4'h5);
        chk("clear_q", q, 8'hF0);
        chk("clear_ovf", ovf, 2'b10);

        // Dump with backpressure
        save(2'b10, 2'b00, 4'h3);
        save(2'b01, 2'b00, 4'hA);
        chk("pre_dump_q", q, 8'hA3);
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b1, 4'hA});
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_busy", busy, 1);
            chk("bp_word", {out_ch, out_data}, {1'b0, 4'h3});
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_second_ch", out_ch, 1);
        tick();
        chk("bp_done_valid", out_valid, 0);
        chk("bp_done_busy", busy, 0);
        out_ready = 1'b0;
        tick();

        // Save while a word is held, and dump_start ignored while busy
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b1, 4'hA});
        dump_start = 1'b1;
        out_ready  = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("held_ch1", {out_ch, out_data}, {1'b1, 4'hA});
        save_n     = 2'b01;
        mode       = 2'b00;
        data_in    = 4'h5;
        dump_start = 1'b1;
        tick();
        save_n = '1;
        chk("save_during_dump_q", q, 8'h53);
        chk("held_word_stable", {out_ch, out_data}, {1'b1, 4'hA});
        tick();
        out_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("final_hs_ignores_start", out_valid, 0);
        repeat (3) begin
            tick();
            chk("no_extra_dump", out_valid, 0);
        end
        out_ready = 1'b0;

        // Reset mid-dump
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("mid_dump_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_q", q, 8'h00);
        chk("async_rst_ovf", ovf, 2'b00);
        tick();
        reset_n = 1'b1;
        tick();
        save(2'b10, 2'b00, 4'h6);
        save(2'b01, 2'b00, 4'h2);
        exp_q.push_back({1'b0, 4'h6});
        exp_q.push_back({1'b1, 4'h2});
        dump_start = 1'b1;
        out_ready  = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("restart_ch0", out_ch, 0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);
        chk("end_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/latch_bank_acc.md
# latch_bank_acc

Parametrised multi-channel latch bank, the successor to the fixed two-channel, 4-bit latch pair in the sum/latch/UART system. Each channel captures, accumulates (wrapping or saturating) or clears on the falling edge of its own active-low save strobe. A built-in readout sequencer scans all channels out over a valid/ready stream, which feeds the UART transmitter path. Parallel outputs remain available for direct pin display.

## Interface
Parameters:
- NCH, 2: number of channels (≥1)
- DW, 4: data width per channel (≥1)
- CW, $clog2(NCH) (min 1): channel index width (derived)

Ports:
- clk  in  1  single system clock; all state on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- save_n  in  NCH  per-channel active-low save strobes, synchronous to clk
- data_in  in  DW  operand shared by all channels
- mode  in  2  operation: 00 load, 01 add-wrap, 10 add-saturate, 11 clear
- q  out  NCH*DW  channel values; channel i at q[i*DW +: DW]
- ovf  out  NCH  sticky per-channel overflow flags
- dump_start  in  1  single-cycle request to scan all channels out
- out_data  out  DW  readout word
- out_ch  out  CW  channel index of out_data
- out_valid  out  1  readout word valid
- out_ready  in  1  downstream accepts word
- busy  out  1  readout sequence in progress

## Operation
- Reset (asynchronous assert, any time): q=0, ovf=0, save_n history=all ones, out_valid=0, busy=0, out_ch=0, out_data=0, FSM=IDLE. An in-progress dump is abandoned.
- Save event on channel i: history bit 1 and current save_n[i] sampled 0. Holding save_n low gives exactly one event. Any number of channels may fire in the same cycle; all use the same data_in and mode.
- Per-event action on channel i, using mode sampled in the event cycle:
  - 00 load: q_i←data_in; ovf_i←0.
  - 01 add-wrap: q_i←(q_i+data_in) mod 2^DW; ovf_i set if a carry out of bit DW-1 occurs, otherwise unchanged.
  - 10 add-saturate: q_i←min(q_i+data_in, 2^DW-1); ovf_i set if the true sum exceeds 2^DW-1.
  - 11 clear: q_i←0; ovf_i←0.
- The sum is computed at DW+1 bits. Channels without an event hold their value.
- Readout FSM:
  - IDLE: busy=0, out_valid=0. dump_start=1 → SEND with out_ch=0, out_data=q_0, out_valid=1, busy=1.
  - SEND, out_valid & out_ready, out_ch<NCH-1 → out_ch+1, out_data=q of the next channel, out_valid stays 1 (back-to-back words, no bubble).
  - SEND, out_valid & out_ready, out_ch=NCH-1 → IDLE; out_valid=0, busy=0.
  - SEND, !out_ready → out_data and out_ch are held stable.
  - dump_start is ignored while busy.
- Captured words come from the pre-edge register value, so a save in the capture cycle is not reflected. Saves never alter a word already presented.

## Timing
- Save latency: q and ovf update at the same clock edge at which save_n is first sampled low. The new value is visible immediately after that edge.
- Dump latency: dump_start sampled at edge t → out_valid=1 after edge t.
- A full dump takes NCH accept cycles minimum. busy falls at the edge of the final handshake.
- dump_start in the same cycle as the final handshake is ignored (the FSM is still busy). A new dump may start the following cycle.
- No combinational path from any input to any output.

## Test plan
- Reset/load: NCH=2, DW=4. After reset, q=0x00 and ovf=00. Pulse save_n=10 (ch0 low) with mode=00, data_in=0x9 → q=0x09. Hold save_n low 5 cycles → exactly one update.
- Wrap: ch1 loaded with 0xC, then mode=01, data_in=0x7, save ch1 → q_1=0x3, ovf=10. Then add 0x1 → q_1=0x4, ovf still 10. Load → ovf_1=0.
- Saturate and simultaneous events: both channels at 0xE, mode=10, data_in=0x5, save_n=00 in one cycle → q=0xFF, ovf=11. Then mode=11 on ch0 only → q_0=0, ovf=10.
- Dump with backpressure: q_0=0x3, q_1=0xA. Pulse dump_start with out_ready=0 for 3 cycles → out_ch=0 and out_data=0x3 held, busy=1. Set out_ready=1 → words (0,0x3) then (1,0xA) on consecutive cycles, then out_valid=0 and busy=0.
- Save during dump: while word (1,0xA) is held unaccepted, load ch1 with 0x5 → out_data stays 0xA and q_1=0x5. dump_start pulses while busy are ignored (only NCH words are emitted).
- Reset mid-dump: assert reset_n=0 while out_valid=1 → out_valid, busy, q and ovf are 0 immediately, without a clock edge. After release, a dump restarts from channel 0.
